// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and run-control stage ahead of control_unit.
// Holds the fetch PC and advances it on every committed cycle. Runs a
// start / pause / single-step / halt state machine and produces the exec_en
// commit strobe that gates architectural side effects downstream.
module pc_sequencer #(
   parameter int                ADDR_W      = 15,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter logic [5:0]        HALT_OPCODE = 6'b111111
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              halt_req,
   input  logic              step,
   input  logic [31:0]       instr,
   input  logic              PC_control,
   input  logic [ADDR_W-1:0] j_instr_addr,
   output logic [ADDR_W-1:0] PC,
   output logic              exec_en,
   output logic [1:0]        state_o,
   output logic [31:0]       retired,
   output logic              pc_wrap
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] pc_reg;
   logic [31:0]       retired_reg;
   logic              pc_wrap_reg;

   logic              is_halt;
   logic              commit;
   logic              load_start;
   logic [ADDR_W-1:0] pc_plus_one;
   logic [ADDR_W-1:0] next_pc;
   logic              seq_wrap;

   // Only the opcode field matters here; the rest of the word belongs to
   // control_unit.
   logic unused_instr_bits;
   assign unused_instr_bits = ^instr[25:0];

   assign is_halt     = (instr[31:26] == HALT_OPCODE);
   assign pc_plus_one = pc_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign next_pc     = PC_control ? j_instr_addr : pc_plus_one;
   // A sequential increment from all-ones wraps to zero.
   assign seq_wrap    = !PC_control && (pc_reg == {ADDR_W{1'b1}});

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state decode, commit strobe and start-load request.
   always_comb begin
      state_next = state_reg;
      commit     = 1'b0;
      load_start = 1'b0;
      unique case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_next = ST_RUN;
               load_start = 1'b1;
            end
         end
         ST_RUN: begin
            // The halt word wins over a pause request so the PC parks on it.
            if (is_halt) begin
               state_next = ST_DONE;
            end else if (halt_req) begin
               state_next = ST_PAUSE;
            end else begin
               commit = 1'b1;
            end
         end
         ST_PAUSE: begin
            if (step && is_halt) begin
               state_next = ST_DONE;
            end else if (step) begin
               commit = 1'b1;
            end else if (!halt_req) begin
               state_next = ST_RUN;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // PC, retired-count and wrap-flag datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_reg      <= RESET_PC;
         retired_reg <= 32'd0;
         pc_wrap_reg <= 1'b0;
      end else if (load_start) begin
         pc_reg      <= start_addr;
         retired_reg <= 32'd0;
         pc_wrap_reg <= 1'b0;
      end else if (commit) begin
         pc_reg      <= next_pc;
         retired_reg <= retired_reg + 32'd1;
         if (seq_wrap) begin
            pc_wrap_reg <= 1'b1;
         end
      end
   end

   // The rst term keeps the strobe low for the whole reset window, even
   // before the first edge has settled the state register.
   assign exec_en = commit && !rst;
   assign PC      = pc_reg;
   assign state_o = state_reg;
   assign retired = retired_reg;
   assign pc_wrap = pc_wrap_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by randomized
// stimulus, all checked every cycle against a behavioural reference model.
module tb_pc_sequencer;

   localparam int AW      = 15;
   localparam int PC_MOD  = 1 << AW;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic          halt_req = 1'b0;
   logic          step = 1'b0;
   logic [31:0]   instr = 32'd0;
   logic          PC_control = 1'b0;
   logic [AW-1:0] j_instr_addr = '0;
   logic [AW-1:0] PC;
   logic          exec_en;
   logic [1:0]    state_o;
   logic [31:0]   retired;
   logic          pc_wrap;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state.
   int      m_mode;
   int      m_pc;
   bit [31:0] m_ret;
   bit      m_wrap;

   pc_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .start_addr  (start_addr),
      .halt_req    (halt_req),
      .step        (step),
      .instr       (instr),
      .PC_control  (PC_control),
      .j_instr_addr(j_instr_addr),
      .PC          (PC),
      .exec_en     (exec_en),
      .state_o     (state_o),
      .retired     (retired),
      .pc_wrap     (pc_wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_mode = M_IDLE;
      m_pc   = 0;
      m_ret  = 32'd0;
      m_wrap = 1'b0;
   endfunction

   function automatic logic [31:0] make_instr(input bit halt_op);
      logic [5:0] op;
      op = halt_op ? 6'h3F : 6'($urandom_range(0, 62));
      return {op, 26'($urandom)};
   endfunction

   // One clock cycle: drive inputs just after an edge, compare mid-cycle,
   // advance the model, then step past the next rising edge.
   task automatic cycle(input bit st, input int sa, input bit hr, input bit sp,
                        input bit hop, input bit pcc, input int ja);
      bit go;
      start        = st;
      start_addr   = AW'(sa);
      halt_req     = hr;
      step         = sp;
      instr        = make_instr(hop);
      PC_control   = pcc;
      j_instr_addr = AW'(ja);
      #2;
      go = ((m_mode == M_RUN) && !hr && !hop) || ((m_mode == M_PAUSE) && sp && !hop);
      check("pc",      32'(PC),      32'(m_pc));
      check("state",   32'(state_o), 32'(m_mode));
      check("retired", retired,      m_ret);
      check("pc_wrap", 32'(pc_wrap), 32'(m_wrap));
      check("exec_en", 32'(exec_en), 32'(go));
      $display("cyc st=%0b sa=%04h hr=%0b sp=%0b hlt=%0b pcc=%0b ja=%04h | pc=%04h state=%0d ret=%0d wrap=%0b en=%0b",
               st, sa, hr, sp, hop, pcc, ja, PC, state_o, retired, pc_wrap, exec_en);
      if (go) begin
         if (!pcc && m_pc == PC_MOD - 1) m_wrap = 1'b1;
         m_pc  = pcc ? ja : (m_pc + 1) % PC_MOD;
         m_ret = m_ret + 32'd1;
      end
      case (m_mode)
         M_IDLE, M_DONE: if (st) begin
            m_mode = M_RUN; m_pc = sa; m_ret = 32'd0; m_wrap = 1'b0;
         end
         M_RUN: begin
            if (hop) m_mode = M_DONE;
            else if (hr) m_mode = M_PAUSE;
         end
         default: begin
            if (sp && hop) m_mode = M_DONE;
            else if (!sp && !hr) m_mode = M_RUN;
         end
      endcase
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_pc"},      32'(PC),      32'd0);
      check({tag, "_state"},   32'(state_o), 32'd0);
      check({tag, "_retired"}, retired,      32'd0);
      check({tag, "_wrap"},    32'(pc_wrap), 32'd0);
      check({tag, "_exec_en"}, 32'(exec_en), 32'd0);
   endtask

   initial begin
      model_reset();
      #3;
      check_reset_values("rst");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Straight-line code from 0x0010.
      cycle(1, 16'h0010, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0, 0);
      // Redirect to 0x0020, then from 0x0020 to 0x0100.
      cycle(0, 0, 0, 0, 0, 1, 16'h0020);
      cycle(0, 0, 0, 0, 0, 1, 16'h0100);
      cycle(0, 0, 0, 0, 0, 1, 16'h0005);
      // Pause at 0x0005, three single steps, then resume.
      cycle(0, 0, 1, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 1, 1, 0, 0, 0);
         cycle(0, 0, 1, 0, 0, 0, 0);
      end
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      // Halt word at 0x0040 with halt_req in the same cycle.
      cycle(0, 0, 0, 0, 0, 1, 16'h0040);
      cycle(0, 0, 1, 0, 1, 0, 0);
      cycle(0, 0, 1, 1, 0, 0, 0);
      cycle(1, 16'h0000, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      // Halt, then restart at 0x7FFF and wrap sequentially.
      cycle(0, 0, 0, 0, 1, 0, 0);
      cycle(1, 16'h7FFF, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      cycle(1, 16'h0100, 0, 0, 0, 0, 0);
      // Asynchronous reset mid-PAUSE while step is high.
      cycle(0, 0, 1, 0, 0, 0, 0);
      step     = 1'b1;
      halt_req = 1'b1;
      instr    = make_instr(0);
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("arst");
      model_reset();
      @(posedge clk);
      #1;
      check_reset_values("arst_hold");
      rst = 1'b0;
      step = 1'b0;
      halt_req = 1'b0;

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         int sa, ja;
         sa = ($urandom_range(0, 7) == 0) ? 16'h7FFF - int'($urandom_range(0, 2)) : int'($urandom_range(0, PC_MOD - 1));
         ja = ($urandom_range(0, 7) == 0) ? 16'h7FFF : int'($urandom_range(0, PC_MOD - 1));
         cycle($urandom_range(0, 9) == 0, sa, $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 4) == 0, ja);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and run-control stage directly upstream of `control_unit`. It holds the 15-bit `PC` that drives instruction fetch and advances it each committed cycle, to `PC+1` or to the redirect target (`j_instr_addr` when `PC_control`=1). It runs a start/pause/single-step/halt state machine and provides an `exec_en` commit strobe. The core wrapper ANDs `exec_en` into the register-file and data-memory write enables, so a held PC never re-executes side effects.

## Interface
- `ADDR_W`, 15: PC / instruction-address width.
- `RESET_PC`, 15'h0000: PC value after reset.
- `HALT_OPCODE`, 6'b111111: opcode (`instr[31:26]`) that stops execution.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: pulse; loads `start_addr` and begins execution (IDLE/DONE only).
- `start_addr` in ADDR_W: entry address captured on `start`.
- `halt_req` in 1: level; pauses execution while high.
- `step` in 1: pulse; commits exactly one instruction while paused.
- `instr` in 32: fetched word at current `PC`, used only for halt-opcode decode.
- `PC_control` in 1: redirect request from `control_unit`.
- `j_instr_addr` in ADDR_W: redirect target from `control_unit`.
- `PC` out ADDR_W: current fetch address (registered).
- `exec_en` out 1: this cycle's instruction commits (combinational).
- `state_o` out 2: 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
- `retired` out 32: committed-instruction count (registered).
- `pc_wrap` out 1: sticky flag; a sequential increment wrapped past all-ones.

## Operation
- Definitions:
  - `is_halt` = (`instr[31:26]` == HALT_OPCODE).
  - `next_pc` = `PC_control` ? `j_instr_addr` : `PC`+1, computed modulo 2^ADDR_W.
- `exec_en` = (RUN & !`halt_req` & !`is_halt`) | (PAUSE & `step` & !`is_halt`).
  - Asserted while IDLE or DONE is not permitted.
- Commit cycle (`exec_en`=1):
  - `PC` <= `next_pc`.
  - `retired` <= `retired`+1, wrapping at 2^32.
  - If `PC_control`=0 and `PC` is all-ones, set `pc_wrap`.
- Non-commit cycle: `PC` and `retired` hold.
- State transitions, evaluated in priority order within each state:
  - IDLE: `start` → RUN, with `PC`<=`start_addr`, `retired`<=0, `pc_wrap`<=0. Otherwise stay in IDLE.
  - RUN:
    - `is_halt` → DONE. `PC` holds at the halt word. This takes priority over `halt_req`.
    - Otherwise, `halt_req` → PAUSE. No commit this cycle.
    - Otherwise, commit and stay in RUN.
    - `start` and `step` are ignored.
  - PAUSE:
    - `step` & `is_halt` → DONE, no commit.
    - `step` → commit one instruction and stay in PAUSE.
    - `halt_req`=0 (no `step`) → RUN. The first commit happens the following cycle.
    - `start` is ignored.
  - DONE: `start` → RUN, with the same loads as from IDLE. Otherwise hold. `step` and `halt_req` are ignored.
- Reset (any time, including mid-step): state IDLE, `PC`=RESET_PC, `retired`=0, `pc_wrap`=0. `exec_en` is 0 while `rst` is high.
- `j_instr_addr` is used verbatim. No alignment or range check.

## Timing
- Reset values: `PC`=RESET_PC, `state_o`=00, `retired`=0, `pc_wrap`=0, `exec_en`=0.
- `start` at edge N: `PC`=`start_addr` and `state_o`=01 after edge N. The first commit is the cycle between edges N and N+1.
- RUN throughput: one instruction per cycle. A redirect or increment is visible on `PC` one edge after the commit cycle.
- `exec_en` and `is_halt` are combinational from `instr`, so `instr` must be valid within the same cycle as `PC`. Fetch is combinational.
- `halt_req` asserted during cycle N: no commit in cycle N, and PAUSE is entered at edge N.
- `step` held for k cycles in PAUSE commits k instructions. The bench drives single-cycle pulses.
- `pc_wrap` and `retired` update on the same edge as the commit that causes them.

## Test plan
- Reset then `start`, `start_addr`=0x0010, with straight-line non-branch code → `PC` reads 0x0010, 0x0011, 0x0012, … one per cycle; `retired` = number of commit cycles; `exec_en`=1 continuously.
- In RUN at `PC`=0x0020, drive `PC_control`=1 and `j_instr_addr`=0x0100 → `PC`=0x0100 after one edge; `retired` +1; no `pc_wrap`.
- Assert `halt_req` at `PC`=0x0005 → `PC` holds at 0x0005 and `exec_en`=0. Issue 3 `step` pulses → `PC`=0x0008 and `retired` +3. Drop `halt_req` → state RUN next cycle, and commits resume.
- `instr` with opcode 6'b111111 at `PC`=0x0040 while `halt_req`=1 the same cycle → DONE; `PC` stays 0x0040; `retired` unchanged. Then `start`, `start_addr`=0x0000 → RUN; `retired`=0; `PC`=0x0000.
- `start_addr`=0x7FFF, sequential instruction → `PC`=0x0000 and `pc_wrap`=1 after the commit. `pc_wrap` stays 1 until the next `start`.
- Assert `rst` asynchronously mid-PAUSE while `step` is high → outputs return immediately to the reset values with no clock edge, and no commit occurs.
